// File: rtl/key_event_detector.sv
// rtl/key_event_detector.sv - synchronise, debounce and classify N active-low push keys
module key_event_detector #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_out,
    output logic [N_KEYS-1:0] long_out,
    output logic [N_KEYS-1:0] key_level
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_P,
        S_HELD,
        S_LONG,
        S_DEB_R
    } state_t;

    // Debounce windows end one count early because the IDLE/HELD edge that
    // enters the window already consumes one stable cycle.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] ks;

    // Two-flop synchroniser, preset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            ks    <= '1;
        end else begin
            sync1 <= key_in;
            ks    <= sync1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic             fired, fired_nx;
        logic             press_r, press_nx;
        logic             long_r, long_nx;
        logic             level_r, level_nx;

        // Per-key state, counter and registered event outputs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                cnt     <= '0;
                fired   <= 1'b0;
                press_r <= 1'b0;
                long_r  <= 1'b0;
                level_r <= 1'b0;
            end else begin
                state   <= state_nx;
                cnt     <= cnt_nx;
                fired   <= fired_nx;
                press_r <= press_nx;
                long_r  <= long_nx;
                level_r <= level_nx;
            end
        end

        // Next-state: debounce press/release, time the long hold
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            fired_nx = fired;
            press_nx = 1'b0;
            long_nx  = 1'b0;
            level_nx = level_r;
            case (state)
                S_IDLE: begin
                    fired_nx = 1'b0;
                    if (!ks[g]) begin
                        state_nx = S_DEB_P;
                        cnt_nx   = '0;
                    end
                end
                S_DEB_P: begin
                    if (ks[g]) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nx = S_HELD;
                        cnt_nx   = '0;
                        fired_nx = 1'b0;
                        press_nx = 1'b1;
                        level_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (ks[g]) begin
                        state_nx = S_DEB_R;
                        cnt_nx   = '0;
                    end else if (cnt == LONG_LAST) begin
                        state_nx = S_LONG;
                        cnt_nx   = '0;
                        fired_nx = 1'b1;
                        long_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_LONG: begin
                    if (ks[g]) begin
                        state_nx = S_DEB_R;
                        cnt_nx   = '0;
                    end
                end
                S_DEB_R: begin
                    if (!ks[g]) begin
                        // Release glitch: resume the hold without re-announcing it
                        state_nx = fired ? S_LONG : S_HELD;
                        cnt_nx   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                        fired_nx = 1'b0;
                        level_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        assign key_out[g]   = press_r;
        assign long_out[g]  = long_r;
        assign key_level[g] = level_r;
    end

endmodule
